// File: rtl/noc_port_arbiter.sv
// N-port request arbiter for a shared upstream NoC port. Each downstream
// port has a small request FIFO. A round-robin scan merges the FIFOs onto
// one registered upstream beat with ready back-pressure. Upstream responses
// are steered back to the owning downstream port by their bus-port id.
module noc_port_arbiter #(
   parameter int N_PORTS    = 4,
   parameter int DATA_BYTES = 32,
   parameter int BP_W       = 6,
   parameter int FIFO_DEPTH = 4,
   parameter int PORT_BASE  = 0
) (
   input  logic                                   fclk,
   input  logic                                   rst,
   input  logic [N_PORTS-1:0][DATA_BYTES-1:0][7:0] dn_inp_dat,
   input  logic [N_PORTS-1:0][BP_W-1:0]            dn_inp_bp,
   input  logic [N_PORTS-1:0]                      dn_inp_bo,
   output logic [N_PORTS-1:0]                      dn_inp_rdy,
   output logic [DATA_BYTES-1:0][7:0]              dn_oup_dat,
   output logic [BP_W-1:0]                         dn_oup_bp,
   output logic [N_PORTS-1:0]                      dn_oup_bo,
   output logic [DATA_BYTES-1:0][7:0]              up_oup_dat,
   output logic [BP_W-1:0]                         up_oup_bp,
   output logic                                    up_oup_bo,
   input  logic                                    up_oup_rdy,
   input  logic [DATA_BYTES-1:0][7:0]              up_inp_dat,
   input  logic [BP_W-1:0]                         up_inp_bp,
   input  logic                                    up_inp_bo,
   output logic [15:0]                             drop_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int GW = $clog2(N_PORTS);
   localparam int BW = DATA_BYTES * 8;
   localparam int IW = BP_W + 1;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Request FIFO storage (payload only, never reset) and pointers with wrap bit
   logic [BW-1:0]   mem_dat_q [N_PORTS][FIFO_DEPTH];
   logic [BP_W-1:0] mem_bp_q  [N_PORTS][FIFO_DEPTH];
   logic [AW:0]     wr_ptr_q  [N_PORTS];
   logic [AW:0]     wr_ptr_d  [N_PORTS];
   logic [AW:0]     rd_ptr_q  [N_PORTS];
   logic [AW:0]     rd_ptr_d  [N_PORTS];

   logic [N_PORTS-1:0] empty;
   logic [N_PORTS-1:0] full;
   logic [N_PORTS-1:0] push;
   logic [N_PORTS-1:0] pop;

   // Upstream output register and round-robin pointer
   logic [BW-1:0]   up_dat_q, up_dat_d;
   logic [BP_W-1:0] up_bp_q,  up_bp_d;
   logic            up_bo_q,  up_bo_d;
   logic [GW-1:0]   last_q,   last_d;

   // Response register and drop counter
   logic [BW-1:0]      dn_dat_q, dn_dat_d;
   logic [BP_W-1:0]    dn_bp_q,  dn_bp_d;
   logic [N_PORTS-1:0] dn_bo_q,  dn_bo_d;
   logic [15:0]        drop_q,   drop_d;

   logic            free;
   logic            grant_vld;
   logic [GW-1:0]   grant_idx;
   int              scan;
   logic [BW-1:0]   head_dat;
   logic [BP_W-1:0] head_bp;
   logic [IW-1:0]   resp_idx;
   logic            resp_hit;

   // FIFO status from registered pointers; rdy never sees the incoming bo
   always_comb begin
      empty = '0;
      full  = '0;
      push  = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
         full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                    (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
         push[i]  = dn_inp_bo[i] && !full[i];
      end
      dn_inp_rdy = ~full & {N_PORTS{rst}};
   end

   // Round-robin scan starting one past the last granted port
   always_comb begin
      free      = !up_bo_q || up_oup_rdy;
      grant_vld = 1'b0;
      grant_idx = '0;
      scan      = 0;
      for (int k = 0; k < N_PORTS; k++) begin
         scan = int'(last_q) + 1 + k;
         if (scan >= N_PORTS) scan = scan - N_PORTS;
         if (!grant_vld && !empty[scan]) begin
            grant_vld = 1'b1;
            grant_idx = GW'(scan);
         end
      end
      pop = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         pop[i] = free && grant_vld && (grant_idx == GW'(i));
      end
      head_dat = mem_dat_q[grant_idx][rd_ptr_q[grant_idx][AW-1:0]];
      head_bp  = mem_bp_q[grant_idx][rd_ptr_q[grant_idx][AW-1:0]];
   end

   // Next pointers and output register load; outputs hold while stalled
   always_comb begin
      for (int i = 0; i < N_PORTS; i++) begin
         wr_ptr_d[i] = wr_ptr_q[i] + (AW+1)'(push[i]);
         rd_ptr_d[i] = rd_ptr_q[i] + (AW+1)'(pop[i]);
      end
      up_dat_d = up_dat_q;
      up_bp_d  = up_bp_q;
      up_bo_d  = up_bo_q;
      last_d   = last_q;
      if (free) begin
         up_bo_d = grant_vld;
         if (grant_vld) begin
            up_dat_d = head_dat;
            up_bp_d  = head_bp;
            last_d   = grant_idx;
         end
      end
   end

   // Response steering: one-hot valid for routable ids, count the rest
   always_comb begin
      resp_idx = IW'(up_inp_bp) - IW'(PORT_BASE);
      resp_hit = up_inp_bo && (resp_idx < IW'(N_PORTS));
      dn_dat_d = dn_dat_q;
      dn_bp_d  = dn_bp_q;
      dn_bo_d  = '0;
      drop_d   = drop_q;
      for (int i = 0; i < N_PORTS; i++) begin
         dn_bo_d[i] = resp_hit && (resp_idx == IW'(i));
      end
      if (resp_hit) begin
         dn_dat_d = up_inp_dat;
         dn_bp_d  = up_inp_bp;
      end else if (up_inp_bo) begin
         drop_d = sat_inc16(drop_q);
      end
   end

   // FIFO payload write
   always_ff @(posedge fclk) begin
      for (int i = 0; i < N_PORTS; i++) begin
         if (push[i]) begin
            mem_dat_q[i][wr_ptr_q[i][AW-1:0]] <= dn_inp_dat[i];
            mem_bp_q[i][wr_ptr_q[i][AW-1:0]]  <= dn_inp_bp[i];
         end
      end
   end

   // State registers; reset empties every FIFO and gives port 0 first priority
   always_ff @(posedge fclk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_PORTS; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
         end
         up_dat_q <= '0;
         up_bp_q  <= '0;
         up_bo_q  <= 1'b0;
         last_q   <= GW'(N_PORTS - 1);
         dn_dat_q <= '0;
         dn_bp_q  <= '0;
         dn_bo_q  <= '0;
         drop_q   <= '0;
      end else begin
         for (int i = 0; i < N_PORTS; i++) begin
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
         end
         up_dat_q <= up_dat_d;
         up_bp_q  <= up_bp_d;
         up_bo_q  <= up_bo_d;
         last_q   <= last_d;
         dn_dat_q <= dn_dat_d;
         dn_bp_q  <= dn_bp_d;
         dn_bo_q  <= dn_bo_d;
         drop_q   <= drop_d;
      end
   end

   assign up_oup_dat = up_dat_q;
   assign up_oup_bp  = up_bp_q;
   assign up_oup_bo  = up_bo_q;
   assign dn_oup_dat = dn_dat_q;
   assign dn_oup_bp  = dn_bp_q;
   assign dn_oup_bo  = dn_bo_q;
   assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Bench for noc_port_arbiter: per-port queues and a round-robin scan as the
// reference, response table vectors, and directed multi-cycle sequences.
module tb_noc_port_arbiter;
   localparam int N = 4, DB = 32, BPW = 6, DEPTH = 4, PB = 0;
   localparam int BW = DB * 8;

   logic fclk = 1'b0;
   logic rst  = 1'b0;
   always #5 fclk = ~fclk;

   logic [N-1:0][DB-1:0][7:0] dn_inp_dat;
   logic [N-1:0][BPW-1:0]     dn_inp_bp;
   logic [N-1:0]              dn_inp_bo;
   logic [N-1:0]              dn_inp_rdy;
   logic [DB-1:0][7:0]        dn_oup_dat;
   logic [BPW-1:0]            dn_oup_bp;
   logic [N-1:0]              dn_oup_bo;
   logic [DB-1:0][7:0]        up_oup_dat;
   logic [BPW-1:0]            up_oup_bp;
   logic                      up_oup_bo;
   logic                      up_oup_rdy;
   logic [DB-1:0][7:0]        up_inp_dat;
   logic [BPW-1:0]            up_inp_bp;
   logic                      up_inp_bo;
   logic [15:0]               drop_cnt;

   noc_port_arbiter #(.N_PORTS(N), .DATA_BYTES(DB), .BP_W(BPW),
                      .FIFO_DEPTH(DEPTH), .PORT_BASE(PB)) dut (
      .fclk(fclk), .rst(rst),
      .dn_inp_dat(dn_inp_dat), .dn_inp_bp(dn_inp_bp), .dn_inp_bo(dn_inp_bo),
      .dn_inp_rdy(dn_inp_rdy), .dn_oup_dat(dn_oup_dat), .dn_oup_bp(dn_oup_bp),
      .dn_oup_bo(dn_oup_bo), .up_oup_dat(up_oup_dat), .up_oup_bp(up_oup_bp),
      .up_oup_bo(up_oup_bo), .up_oup_rdy(up_oup_rdy), .up_inp_dat(up_inp_dat),
      .up_inp_bp(up_inp_bp), .up_inp_bo(up_inp_bo), .drop_cnt(drop_cnt));

   typedef struct { logic [BW-1:0] dat; logic [BPW-1:0] bp; } beat_t;
   typedef struct { logic [BPW-1:0] bp; logic [N-1:0] exp_bo; int exp_drop; } rvec_t;

   // reference model state
   beat_t      q [N][$];
   bit         m_ov;
   beat_t      m_ob;
   int         m_last;
   logic [N-1:0] m_dn_bo;
   beat_t      m_dn;
   int         m_drop;

   // request sources
   bit    pend_v [N];
   beat_t pend   [N];

   int n_vec = 0, n_err = 0;
   bit fair_mode = 0;
   int fair_cnt [N];
   int fair_total = 0;
   int deliv_cnt = 0;

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [BW-1:0] rand_beat();
      logic [BW-1:0] r;
      for (int k = 0; k < BW / 32; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         q[i].delete();
         pend_v[i] = 0;
      end
      m_ov = 0; m_ob.dat = '0; m_ob.bp = '0; m_last = N - 1;
      m_dn_bo = '0; m_dn.dat = '0; m_dn.bp = '0; m_drop = 0;
   endtask

   task automatic new_beat(input int i, input logic [BPW-1:0] bp);
      pend_v[i] = 1;
      pend[i].dat = rand_beat();
      pend[i].bp = bp;
   endtask

   // One clock: drive sources, predict the edge, then compare after it.
   task automatic cycle();
      logic [N-1:0] rdy_m, push_m;
      bit found;
      int p, idx;
      beat_t nb;
      for (int i = 0; i < N; i++) begin
         dn_inp_bo[i]  = pend_v[i];
         dn_inp_dat[i] = pend[i].dat;
         dn_inp_bp[i]  = pend[i].bp;
      end
      #1;
      for (int i = 0; i < N; i++) rdy_m[i] = (q[i].size() < DEPTH);
      chk("dn_inp_rdy", BW'(dn_inp_rdy), BW'(rdy_m));
      if (up_oup_bo && up_oup_rdy) begin
         deliv_cnt++;
         if (fair_mode) begin
            chk("grant_order", BW'(up_oup_bp), BW'(fair_total % N));
            if (int'(up_oup_bp) < N) fair_cnt[up_oup_bp]++;
            fair_total++;
         end
      end
      for (int i = 0; i < N; i++) push_m[i] = dn_inp_bo[i] && rdy_m[i];
      if (!m_ov || up_oup_rdy) begin
         found = 0;
         for (int k = 0; k < N; k++) begin
            p = (m_last + 1 + k) % N;
            if (!found && q[p].size() > 0) begin
               found = 1;
               m_ob = q[p].pop_front();
               m_last = p;
            end
         end
         m_ov = found;
      end
      for (int i = 0; i < N; i++) begin
         if (push_m[i]) begin
            nb.dat = dn_inp_dat[i];
            nb.bp  = dn_inp_bp[i];
            q[i].push_back(nb);
         end
      end
      m_dn_bo = '0;
      if (up_inp_bo) begin
         idx = int'(up_inp_bp) - PB;
         if (idx >= 0 && idx < N) begin
            m_dn_bo[idx] = 1'b1;
            m_dn.dat = up_inp_dat;
            m_dn.bp = up_inp_bp;
         end else if (m_drop < 65535) begin
            m_drop++;
         end
      end
      @(posedge fclk);
      #1;
      chk("up_oup_bo", BW'(up_oup_bo), BW'(m_ov));
      if (m_ov) begin
         chk("up_oup_dat", up_oup_dat, m_ob.dat);
         chk("up_oup_bp", BW'(up_oup_bp), BW'(m_ob.bp));
      end
      chk("dn_oup_bo", BW'(dn_oup_bo), BW'(m_dn_bo));
      chk("dn_oup_dat", dn_oup_dat, m_dn.dat);
      chk("dn_oup_bp", BW'(dn_oup_bp), BW'(m_dn.bp));
      chk("drop_cnt", BW'(drop_cnt), BW'(m_drop));
      for (int i = 0; i < N; i++) if (push_m[i]) pend_v[i] = 0;
      @(negedge fclk);
   endtask

   initial begin
      rvec_t tbl [7];
      logic [BW-1:0] first_dat, s_dat [4];
      int exp_drop, sent, acc, ns;
      bit was;

      tbl[0] = '{bp: 6'd0,  exp_bo: 4'b0001, exp_drop: 0};
      tbl[1] = '{bp: 6'd3,  exp_bo: 4'b1000, exp_drop: 0};
      tbl[2] = '{bp: 6'd9,  exp_bo: 4'b0000, exp_drop: 1};
      tbl[3] = '{bp: 6'd4,  exp_bo: 4'b0000, exp_drop: 1};
      tbl[4] = '{bp: 6'd1,  exp_bo: 4'b0010, exp_drop: 0};
      tbl[5] = '{bp: 6'd63, exp_bo: 4'b0000, exp_drop: 1};
      tbl[6] = '{bp: 6'd2,  exp_bo: 4'b0100, exp_drop: 0};

      dn_inp_dat = '0; dn_inp_bp = '0; dn_inp_bo = '0;
      up_oup_rdy = 1'b0; up_inp_dat = '0; up_inp_bp = '0; up_inp_bo = 1'b0;
      for (int i = 0; i < N; i++) fair_cnt[i] = 0;
      model_reset();
      repeat (3) @(negedge fclk);
      rst = 1'b1;
      #1;
      chk("reset_rdy", BW'(dn_inp_rdy), BW'(4'b1111));
      chk("reset_drop", BW'(drop_cnt), '0);
      chk("reset_up_bo", BW'(up_oup_bo), '0);

      // single beat on port 2
      up_oup_rdy = 1'b1;
      new_beat(2, 6'd2);
      pend[2].dat = {8{32'hA5A5A5A5}};
      cycle();
      cycle();
      chk("single_bo", BW'(up_oup_bo), BW'(1'b1));
      chk("single_dat", up_oup_dat, {8{32'hA5A5A5A5}});
      chk("single_bp", BW'(up_oup_bp), BW'(6'd2));
      cycle();

      // response routing table
      exp_drop = 0;
      for (int v = 0; v < 7; v++) begin
         up_inp_bo = 1'b1;
         up_inp_bp = tbl[v].bp;
         up_inp_dat = rand_beat();
         cycle();
         exp_drop += tbl[v].exp_drop;
         chk("resp_bo", BW'(dn_oup_bo), BW'(tbl[v].exp_bo));
         chk("resp_drop", BW'(drop_cnt), BW'(exp_drop));
         up_inp_bo = 1'b0;
         cycle();
         chk("resp_pulse", BW'(dn_oup_bo), '0);
      end

      // back-pressure: six beats on port 1 against a stalled upstream
      up_oup_rdy = 1'b0;
      sent = 0;
      first_dat = '0;
      for (int c = 0; c < 10; c++) begin
         if (!pend_v[1] && sent < 6) begin
            new_beat(1, 6'd1);
            if (sent == 0) first_dat = pend[1].dat;
            sent++;
         end
         cycle();
      end
      chk("bp_rdy1_low", BW'(dn_inp_rdy[1]), '0);
      chk("bp_held_bo", BW'(up_oup_bo), BW'(1'b1));
      chk("bp_held_dat", up_oup_dat, first_dat);
      up_oup_rdy = 1'b1;
      deliv_cnt = 0;
      for (int c = 0; c < 30 && deliv_cnt < 6; c++) cycle();
      chk("bp_delivered", BW'(deliv_cnt), BW'(6));
      repeat (3) cycle();

      // simultaneous push/pop at count 2 with a response in the same cycle
      up_oup_rdy = 1'b0;
      for (int c = 0; c < 3; c++) begin
         new_beat(0, BPW'(c));
         s_dat[c] = pend[0].dat;
         cycle();
      end
      up_oup_rdy = 1'b1;
      new_beat(0, 6'd3);
      s_dat[3] = pend[0].dat;
      up_inp_bo = 1'b1; up_inp_bp = 6'd1; up_inp_dat = rand_beat();
      cycle();
      chk("simul_resp_bo", BW'(dn_oup_bo), BW'(4'b0010));
      chk("simul_up_dat", up_oup_dat, s_dat[1]);
      up_inp_bo = 1'b0;
      up_oup_rdy = 1'b0;
      acc = 0;
      for (int c = 0; c < 4; c++) begin
         if (!pend_v[0]) new_beat(0, 6'd5);
         was = pend_v[0];
         cycle();
         if (was && !pend_v[0]) acc++;
      end
      chk("simul_fill", BW'(acc), BW'(2));
      up_oup_rdy = 1'b1;
      repeat (12) cycle();

      // reset mid-burst with port 2 FIFO full
      up_oup_rdy = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (!pend_v[2]) new_beat(2, 6'd2);
         up_inp_bo = (c < 2);
         up_inp_bp = (c == 0) ? 6'd1 : 6'd9;
         up_inp_dat = rand_beat();
         cycle();
      end
      up_inp_bo = 1'b0;
      chk("rst_pre_full2", BW'(dn_inp_rdy[2]), '0);
      #2 rst = 1'b0;
      #1;
      chk("rst_up_bo", BW'(up_oup_bo), '0);
      chk("rst_up_dat", up_oup_dat, '0);
      chk("rst_up_bp", BW'(up_oup_bp), '0);
      chk("rst_dn_bo", BW'(dn_oup_bo), '0);
      chk("rst_dn_dat", dn_oup_dat, '0);
      chk("rst_dn_bp", BW'(dn_oup_bp), '0);
      chk("rst_drop", BW'(drop_cnt), '0);
      dn_inp_bo = '0;
      model_reset();
      @(posedge fclk);
      @(negedge fclk);
      rst = 1'b1;
      #1;
      chk("rst_rel_rdy", BW'(dn_inp_rdy), BW'(4'b1111));

      // fairness: all ports always valid, upstream always ready
      up_oup_rdy = 1'b1;
      fair_mode = 1;
      for (int c = 0; c < 1000 && fair_total < 400; c++) begin
         for (int i = 0; i < N; i++) if (!pend_v[i]) new_beat(i, BPW'(i));
         cycle();
      end
      fair_mode = 0;
      chk("fair_total", BW'(fair_total), BW'(400));
      for (int i = 0; i < N; i++) chk("fair_share", BW'(fair_cnt[i]), BW'(100));

      // randomized traffic with random back-pressure and responses
      for (int c = 0; c < 1500; c++) begin
         up_oup_rdy = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++)
            if (!pend_v[i] && $urandom_range(0, 2) == 0) new_beat(i, BPW'($urandom));
         up_inp_bo = $urandom_range(0, 1);
         up_inp_bp = BPW'($urandom_range(0, 9));
         up_inp_dat = rand_beat();
         cycle();
      end
      up_inp_bo = 1'b0;
      up_oup_rdy = 1'b1;
      ns = 0;
      for (int c = 0; c < 40; c++) begin
         cycle();
         ns = 0;
         for (int i = 0; i < N; i++) ns += q[i].size();
      end
      chk("drain_empty", BW'(ns), '0);
      chk("drain_bo", BW'(up_oup_bo), '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
